// File: rtl/char_life_pkg.sv
// Shared types and constants for the character life scheduler.
package char_life_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DYING = 2'd2,
      OVER  = 2'd3
   } game_state_t;

   // Bit positions inside the renderer's die broadcast {d, d1, d2, robot}
   localparam int EV_D  = 3;
   localparam int EV_D1 = 2;
   localparam int EV_D2 = 1;
   localparam int EV_R  = 0;

   localparam int SCORE_W = 8;
   localparam int LIVES_W = 2;

endpackage

// File: rtl/char_life_scheduler_respawn_timer.sv
// Tick-driven down-counter: load/clear, expire pulse on the tick that reaches zero.
module respawn_timer #(
   parameter int W = 8
) (
   input  logic         clk_25Hz,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   input  logic         clear,
   output logic         expire,
   output logic         busy
);

   logic [W-1:0] count;

   always_ff @(posedge clk_25Hz or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (tick && busy) begin
         count <= count - 1'b1;
      end
   end

   assign busy   = (count != '0);
   assign expire = tick && (count == W'(1));

endmodule

// File: rtl/char_life_scheduler.sv
// Game-level scheduler for character valid flags, missile, score and robot lives.
// Define LIFE_BONUS_EN to build the extra-life bonus on every 10-point boundary.
//
// state | meaning
// IDLE  | waiting for start, all characters invalid
// PLAY  | game running, kills / respawns / missile active
// DYING | robot down waiting for its respawn timer, missile disabled
// OVER  | no lives left, score and lives frozen until start
module char_life_scheduler
   import char_life_pkg::*;
#(
   parameter int TICK_DIV            = 250000,
   parameter int RESPAWN_TICKS       = 100,
   parameter int ROBOT_RESPAWN_TICKS = 150,
   parameter int ROBOT_LIVES         = 3,
   parameter int MISSILE_LIFE_TICKS  = 80,
   parameter int MISSILE_CD_TICKS    = 50
) (
   input  logic               clk_25Hz,
   input  logic               rst,
   input  logic               start,
   input  logic               fire,
   input  logic [3:0]         die_event,
   output logic               d_valid,
   output logic               d1_valid,
   output logic               d2_valid,
   output logic               r_valid,
   output logic               m_valid,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [1:0]         game_state,
   output logic               game_over
);

   localparam int T_A = (RESPAWN_TICKS > ROBOT_RESPAWN_TICKS) ? RESPAWN_TICKS : ROBOT_RESPAWN_TICKS;
   localparam int T_B = (MISSILE_LIFE_TICKS > MISSILE_CD_TICKS) ? MISSILE_LIFE_TICKS : MISSILE_CD_TICKS;
   localparam int TW  = $clog2(((T_A > T_B) ? T_A : T_B) + 1);
   localparam int PW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TOP = PW'(TICK_DIV - 1);

   game_state_t        state, state_n;
   logic [PW-1:0]      presc;
   logic               tick, active, timer_clear;
   logic [3:0]         die_event_q, rise;
   logic [2:0]         dv, dv_n, kill, d_exp, d_busy, rise_dr;
   logic               r_kill, r_exp, r_busy, rv_n;
   logic               launch, any_kill, m_stop, life_clear, life_exp, life_busy;
   logic               cd_busy, unused_cd_exp, mv_n;
   logic [SCORE_W:0]   score_sum;
   logic [SCORE_W-1:0] score_sat, score_n;
   logic [LIVES_W-1:0] lives_dec, lives_n;

   assign tick        = (state != IDLE) && (presc == PRESC_TOP);
   assign active      = (state == PLAY) || (state == DYING);
   assign timer_clear = !active;
   assign rise        = die_event & ~die_event_q;
   assign rise_dr     = {rise[EV_D2], rise[EV_D1], rise[EV_D]};
   assign kill        = active ? (rise_dr & dv & ~d_busy) : 3'b000;
   assign any_kill    = |kill;
   assign r_kill      = (state == PLAY) && rise[EV_R] && r_valid && !r_busy;
   assign launch      = (state == PLAY) && fire && !m_valid && !cd_busy && !life_busy;
   assign m_stop      = m_valid && (life_exp || any_kill || r_kill);
   // Early missile end must also stop its life counter so no stale expiry lingers
   assign life_clear  = timer_clear || (m_valid && (any_kill || r_kill));

   assign score_sum = {1'b0, score} + (SCORE_W+1)'(kill[0]) + (SCORE_W+1)'(kill[1])
                      + (SCORE_W+1)'(kill[2]);
   assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

`ifdef LIFE_BONUS_EN
   logic bonus;
   assign bonus = (score_sat / SCORE_W'(10)) != (score / SCORE_W'(10));
`endif

   for (genvar i = 0; i < 3; i++) begin : g_dragon
      respawn_timer #(.W(TW)) u_timer (
         .clk_25Hz (clk_25Hz),
         .rst      (rst),
         .load     (kill[i]),
         .load_val (TW'(RESPAWN_TICKS)),
         .tick     (tick),
         .clear    (timer_clear),
         .expire   (d_exp[i]),
         .busy     (d_busy[i])
      );
   end

   respawn_timer #(.W(TW)) u_robot_timer (
      .clk_25Hz (clk_25Hz),
      .rst      (rst),
      .load     (r_kill),
      .load_val (TW'(ROBOT_RESPAWN_TICKS)),
      .tick     (tick),
      .clear    (timer_clear),
      .expire   (r_exp),
      .busy     (r_busy)
   );

   respawn_timer #(.W(TW)) u_life_timer (
      .clk_25Hz (clk_25Hz),
      .rst      (rst),
      .load     (launch),
      .load_val (TW'(MISSILE_LIFE_TICKS)),
      .tick     (tick),
      .clear    (life_clear),
      .expire   (life_exp),
      .busy     (life_busy)
   );

   respawn_timer #(.W(TW)) u_cd_timer (
      .clk_25Hz (clk_25Hz),
      .rst      (rst),
      .load     (m_stop),
      .load_val (TW'(MISSILE_CD_TICKS)),
      .tick     (tick),
      .clear    (timer_clear),
      .expire   (unused_cd_exp),
      .busy     (cd_busy)
   );

   always_comb begin
      state_n   = state;
      dv_n      = dv;
      rv_n      = r_valid;
      mv_n      = m_valid;
      score_n   = score;
      lives_n   = lives;
      lives_dec = r_kill ? lives - 1'b1 : lives;
      case (state)
         IDLE: begin
            dv_n = '0;
            rv_n = 1'b0;
            mv_n = 1'b0;
            if (start) begin
               state_n = PLAY;
               dv_n    = '1;
               rv_n    = 1'b1;
               lives_n = LIVES_W'(ROBOT_LIVES);
               score_n = '0;
            end
         end
         PLAY, DYING: begin
            dv_n    = (dv & ~kill) | d_exp;
            score_n = score_sat;
            lives_n = lives_dec;
`ifdef LIFE_BONUS_EN
            if (bonus && (lives_dec != '1)) lives_n = lives_dec + 1'b1;
`endif
            if (state == PLAY) begin
               if (launch)      mv_n = 1'b1;
               else if (m_stop) mv_n = 1'b0;
               if (r_kill) begin
                  rv_n = 1'b0;
                  mv_n = 1'b0;
                  if (lives == LIVES_W'(1)) begin
                     state_n = OVER;
                     dv_n    = '0;
                  end else begin
                     state_n = DYING;
                  end
               end
            end else begin
               mv_n = 1'b0;
               if (r_exp) begin
                  rv_n    = 1'b1;
                  state_n = PLAY;
               end
            end
         end
         OVER: begin
            dv_n = '0;
            rv_n = 1'b0;
            mv_n = 1'b0;
            if (start) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_25Hz or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         presc       <= '0;
         die_event_q <= '0;
         dv          <= '0;
         r_valid     <= 1'b0;
         m_valid     <= 1'b0;
         lives       <= '0;
         score       <= '0;
         game_over   <= 1'b0;
      end else begin
         state       <= state_n;
         presc       <= ((state == IDLE) || (presc == PRESC_TOP)) ? '0 : presc + 1'b1;
         die_event_q <= die_event;
         dv          <= dv_n;
         r_valid     <= rv_n;
         m_valid     <= mv_n;
         lives       <= lives_n;
         score       <= score_n;
         game_over   <= (state_n == OVER);
      end
   end

   assign d_valid    = dv[0];
   assign d1_valid   = dv[1];
   assign d2_valid   = dv[2];
   assign game_state = state;

endmodule
